// File: rtl/jtframe_sdram_arb.sv
// Round-robin arbiter sharing the game-side SDRAM read port among SLOTS ROM
// requesters. Only one read is in flight; refresh is allowed only while idle.
module jtframe_sdram_arb #(
  parameter int SLOTS   = 4,
  parameter int AW      = 22,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk_sys,
  input  logic                  RESET,
  input  logic                  downloading,
  input  logic [SLOTS-1:0]      slot_req,
  input  logic [SLOTS*AW-1:0]   slot_addr,
  input  logic [SLOTS*2-1:0]    slot_bank,
  output logic [SLOTS-1:0]      slot_ok,
  output logic [SLOTS*32-1:0]   slot_dout,
  output logic                  sdram_req,
  output logic [AW-1:0]         sdram_addr,
  output logic [1:0]            sdram_bank,
  input  logic                  sdram_ack,
  input  logic                  data_rdy,
  input  logic [31:0]           data_read,
  output logic                  refresh_en,
  output logic [7:0]            timeout_cnt,
  output logic [1:0]            state
);

  // Handshake: sdram_req is held high until the cycle sdram_ack is sampled
  // high; data_read is valid only in a cycle with data_rdy high, and only
  // counts while an access is outstanding. slot_ok is a single-cycle pulse.

  localparam int PW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_ACK = 2'd1, WAIT_RDY = 2'd2} state_t;

  state_t          st;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   gnt;
  logic [PW-1:0]   sel;
  logic [PW-1:0]   sel_next;
  logic            found;
  logic [SLOTS-1:0] elig;
  logic [7:0]      cnt;
  logic            done;
  logic            acked;
  logic            expired;

  assign state = st;

  // slot_ok doubles as the last-serviced mask: a req still high during its
  // own ok pulse must not be granted again.
  assign elig = slot_req & ~slot_ok;

  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < SLOTS; k++) begin
      if (!found && elig[(int'(ptr) + k) % SLOTS]) begin
        found = 1'b1;
        sel   = PW'((int'(ptr) + k) % SLOTS);
      end
    end
  end

  assign sel_next = (sel == PW'(SLOTS - 1)) ? '0 : sel + PW'(1);

  assign acked   = (st == WAIT_ACK) && sdram_ack;
  assign done    = (acked && data_rdy) || ((st == WAIT_RDY) && data_rdy);
  assign expired = (st != IDLE) && !done && !acked && (cnt == TO_LAST);

  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      st          <= IDLE;
      ptr         <= '0;
      gnt         <= '0;
      cnt         <= '0;
      slot_ok     <= '0;
      slot_dout   <= '0;
      sdram_req   <= 1'b0;
      sdram_addr  <= '0;
      sdram_bank  <= '0;
      refresh_en  <= 1'b1;
      timeout_cnt <= '0;
    end else begin
      slot_ok <= '0;
      if (downloading) begin
        st         <= IDLE;
        sdram_req  <= 1'b0;
        refresh_en <= 1'b0;
        if (st != IDLE) ptr <= gnt;
      end else if (st == IDLE) begin
        if (found) begin
          sdram_req  <= 1'b1;
          sdram_addr <= slot_addr[sel*AW +: AW];
          sdram_bank <= slot_bank[sel*2 +: 2];
          refresh_en <= 1'b0;
          gnt        <= sel;
          ptr        <= sel_next;
          cnt        <= '0;
          st         <= WAIT_ACK;
        end else begin
          refresh_en <= 1'b1;
        end
      end else if (done) begin
        sdram_req                <= 1'b0;
        slot_ok[gnt]             <= 1'b1;
        slot_dout[gnt*32 +: 32]  <= data_read;
        refresh_en               <= 1'b1;
        st                       <= IDLE;
      end else if (acked) begin
        sdram_req <= 1'b0;
        cnt       <= '0;
        st        <= WAIT_RDY;
      end else if (expired) begin
        // Abandoned slot goes back to the head of the rotation.
        sdram_req  <= 1'b0;
        ptr        <= gnt;
        refresh_en <= 1'b1;
        if (timeout_cnt != 8'hFF) timeout_cnt <= timeout_cnt + 8'd1;
        st         <= IDLE;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end

endmodule
